// File: rtl/decode_ctrl.sv
// RV32I decode stage: classifies fetch words, generates immediates and registers them toward execute.
// Illegal opcodes park the stage in TRAP until the pipeline is flushed.
package decode_ctrl_pkg;
    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5
    } instr_type_e;
endpackage

module imm_gen_32
    import decode_ctrl_pkg::*;
(
    input  logic [31:7]  i_ir,
    input  instr_type_e  i_type,
    output logic [31:0]  o_imm
);
    // Sign-extended immediate assembly for each RV32I format; R-type carries none.
    always_comb begin
        o_imm = '0;
        case (i_type)
            INSTR_I: o_imm = {{20{i_ir[31]}}, i_ir[31:20]};
            INSTR_S: o_imm = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            INSTR_B: o_imm = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
            INSTR_U: o_imm = {i_ir[31:12], 12'b0};
            INSTR_J: o_imm = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end
endmodule

module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [XLEN-1:0]   out_pc,
    output logic [2:0]        out_type,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  decoded_cnt
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_TRAP = 1'b1;

    logic [0:0]        r_state;
    logic              r_out_valid;
    logic              r_out_illegal;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_pc;
    instr_type_e       r_type;
    logic [31:0]       r_imm;
    logic [CNT_W-1:0]  r_cnt;

    instr_type_e       w_type;
    logic              w_illegal;
    logic [31:0]       w_imm;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;
    logic [0:0]        w_state_nxt;
    logic              w_valid_nxt;
    logic              w_illegal_nxt;
    logic              w_load;
    logic              w_cnt_inc;

    // Opcode classification; anything outside the RV32I base map is illegal.
    always_comb begin
        w_type    = INSTR_R;
        w_illegal = 1'b0;
        case (in_ir[6:0])
            7'b0110111, 7'b0010111:                         w_type = INSTR_U;
            7'b1101111:                                     w_type = INSTR_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:                         w_type = INSTR_I;
            7'b1100011:                                     w_type = INSTR_B;
            7'b0100011:                                     w_type = INSTR_S;
            7'b0110011:                                     w_type = INSTR_R;
            default: begin
                w_type    = INSTR_R;
                w_illegal = 1'b1;
            end
        endcase
    end

    imm_gen_32 u_imm_gen (
        .i_ir   (in_ir[31:7]),
        .i_type (w_type),
        .o_imm  (w_imm)
    );

    assign w_in_ready = !flush && (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_consume  = r_out_valid && out_ready;

    // Next-state and control; flush outranks accept, accept outranks a plain consume.
    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_out_valid;
        w_illegal_nxt = r_out_illegal;
        w_load        = 1'b0;
        w_cnt_inc     = w_consume && !r_out_illegal;
        if (flush) begin
            w_state_nxt   = S_RUN;
            w_valid_nxt   = 1'b0;
            w_illegal_nxt = 1'b0;
        end else if (w_accept) begin
            w_load        = 1'b1;
            w_valid_nxt   = 1'b1;
            w_illegal_nxt = w_illegal;
            w_state_nxt   = w_illegal ? S_TRAP : S_RUN;
        end else if (w_consume) begin
            w_valid_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
            r_ir          <= '0;
            r_pc          <= '0;
            r_type        <= INSTR_R;
            r_imm         <= '0;
            r_cnt         <= '0;
        end else begin
            r_out_valid   <= w_valid_nxt;
            r_out_illegal <= w_illegal_nxt;
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_ir   <= in_ir;
                r_pc   <= in_pc;
                r_type <= w_type;
                r_imm  <= w_imm;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_illegal = r_out_illegal;
    assign out_ir      = r_ir;
    assign out_pc      = r_pc;
    assign out_type    = r_type;
    assign out_imm     = r_imm;
    assign out_rd      = r_ir[11:7];
    assign out_rs1     = r_ir[19:15];
    assign out_rs2     = r_ir[24:20];
    assign out_funct3  = r_ir[14:12];
    assign decoded_cnt = r_cnt;
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: a format-level reference model checked every cycle,
// plus hand-computed expectations for the main scenarios.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ir;
    logic [31:0]       in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [31:0]       out_pc;
    logic [2:0]        out_type;
    logic [31:0]       out_imm;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic              out_illegal;
    logic [CNT_W-1:0]  decoded_cnt;

    always #5 clk = ~clk;

    decode_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ir       (in_ir),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ir      (out_ir),
        .out_pc      (out_pc),
        .out_type    (out_type),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_illegal (out_illegal),
        .decoded_cnt (decoded_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA immediate layouts using signed arithmetic.
    function automatic void ref_decode(input logic [31:0] ir, output logic [2:0] t,
                                       output logic [31:0] imm, output logic ill);
        logic signed [31:0] s;
        s   = $signed(ir);
        t   = 3'(INSTR_R);
        imm = 32'h0;
        ill = 1'b0;
        case (ir[6:0])
            7'h37, 7'h17: begin t = 3'(INSTR_U); imm = ir & 32'hFFFF_F000; end
            7'h6F: begin
                t   = 3'(INSTR_J);
                imm = (32'(s >>> 31) << 20) | (32'(ir[19:12]) << 12) |
                      (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin t = 3'(INSTR_I); imm = 32'(s >>> 20); end
            7'h63: begin
                t   = 3'(INSTR_B);
                imm = (32'(s >>> 31) << 12) | (32'(ir[7]) << 11) |
                      (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
            end
            7'h23: begin t = 3'(INSTR_S); imm = (32'(s >>> 25) << 5) | 32'(ir[11:7]); end
            7'h33: t = 3'(INSTR_R);
            default: ill = 1'b1;
        endcase
    endfunction

    logic        m_valid, m_ill, m_trap;
    logic [31:0] m_ir, m_pc, m_imm;
    logic [2:0]  m_type;
    int          m_cnt;
    logic [2:0]  d_type;
    logic [31:0] d_imm;
    logic        d_ill;
    logic        m_rdy, m_hs;

    initial begin
        m_valid = 0; m_ill = 0; m_trap = 0; m_ir = 0; m_pc = 0; m_imm = 0; m_type = 0; m_cnt = 0;
    end

    function automatic logic exp_ready();
        return !flush && !m_trap && (!m_valid || out_ready);
    endfunction

    // Model: one transaction slot, a trap flag and a handshake counter.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 0; m_ill = 0; m_trap = 0; m_ir = 0; m_pc = 0; m_imm = 0; m_type = 0; m_cnt = 0;
        end else begin
            m_rdy = exp_ready();
            m_hs  = m_valid && out_ready;
            if (m_hs && !m_ill) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (flush) begin
                m_valid = 0; m_ill = 0; m_trap = 0;
            end else if (in_valid && m_rdy) begin
                ref_decode(in_ir, d_type, d_imm, d_ill);
                m_valid = 1; m_ir = in_ir; m_pc = in_pc; m_type = d_type; m_imm = d_imm;
                m_ill = d_ill; m_trap = d_ill;
            end else if (m_hs) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cmp_out_illegal", 32'(out_illegal), 32'(m_ill));
            chk("cmp_cnt", 32'(decoded_cnt), 32'(m_cnt));
            if (m_valid) begin
                chk("cmp_ir", out_ir, m_ir);
                chk("cmp_pc", out_pc, m_pc);
                chk("cmp_type", 32'(out_type), 32'(m_type));
                chk("cmp_imm", out_imm, m_imm);
                chk("cmp_fields", {12'h0, out_funct3, out_rs2, out_rs1, out_rd},
                    {12'h0, m_ir[14:12], m_ir[24:20], m_ir[19:15], m_ir[11:7]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ill_words [2];
    logic [31:0] legal [8];

    initial begin
        ill_words = '{32'h0000_0000, 32'h0000_0012};
        legal = '{32'h0000_1097, 32'hFFC1_2083, 32'h0000_80E7, 32'h0000_000F,
                  32'h0000_0073, 32'h0020_81B3, 32'h4020_8133, 32'hFE11_0FA3};
        rst_n = 0; in_valid = 0; in_ir = 0; in_pc = 0; out_ready = 0; flush = 0;
        @(posedge clk); #1;
        running = 1'b1;
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_illegal", 32'(out_illegal), 0);
        chk("rst_cnt", 32'(decoded_cnt), 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1;

        // LUI with execute always ready
        in_valid = 1; in_ir = 32'h1234_5037; in_pc = 32'h100; out_ready = 1;
        step();
        chk("lui_valid", 32'(out_valid), 1);
        chk("lui_type", 32'(out_type), 32'(INSTR_U));
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", 32'(out_rd), 0);
        in_valid = 0;
        step();
        chk("lui_cnt", 32'(decoded_cnt), 1);
        chk("lui_drained", 32'(out_valid), 0);

        // ADDI then BEQ back to back
        in_valid = 1; in_ir = 32'hFFF0_0093; in_pc = 32'h104;
        step();
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_type", 32'(out_type), 32'(INSTR_I));
        chk("addi_rd", 32'(out_rd), 1);
        in_ir = 32'hFE00_0EE3; in_pc = 32'h108;
        step();
        chk("beq_valid", 32'(out_valid), 1);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_type", 32'(out_type), 32'(INSTR_B));
        in_valid = 0;
        step();
        chk("b2b_cnt", 32'(decoded_cnt), 3);

        // Backpressure: SW held while JAL waits
        out_ready = 0; in_valid = 1; in_ir = 32'h0011_2223; in_pc = 32'h10C;
        step();
        chk("sw_imm", out_imm, 32'h4);
        chk("sw_type", 32'(out_type), 32'(INSTR_S));
        in_ir = 32'h0080_00EF; in_pc = 32'h110;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            step();
            chk("bp_hold_imm", out_imm, 32'h4);
            chk("bp_hold_ir", out_ir, 32'h0011_2223);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        step();
        chk("jal_imm", out_imm, 32'h8);
        chk("jal_type", 32'(out_type), 32'(INSTR_J));
        chk("jal_rd", 32'(out_rd), 1);
        in_valid = 0;
        step();
        chk("bp_cnt", 32'(decoded_cnt), 5);

        // Illegal words trap until flush
        for (int w = 0; w < 2; w++) begin
            in_valid = 1; in_ir = ill_words[w]; in_pc = 32'h200;
            step();
            chk("ill_flag", 32'(out_illegal), 1);
            chk("ill_type", 32'(out_type), 32'(INSTR_R));
            chk("ill_imm", out_imm, 0);
            in_ir = 32'h0000_0013;
            step();
            chk("ill_consumed", 32'(out_valid), 0);
            chk("ill_in_ready", 32'(in_ready), 0);
            step();
            chk("ill_cnt", 32'(decoded_cnt), 5);
            in_valid = 0; flush = 1;
            step();
            flush = 0;
            #1;
            chk("trap_exit_ready", 32'(in_ready), 1);
            chk("trap_exit_illegal", 32'(out_illegal), 0);
        end

        // Flush drops a held entry and blocks a same-cycle accept
        out_ready = 0; in_valid = 1; in_ir = 32'hFFF0_0093; in_pc = 32'h300;
        step();
        chk("fl_held", 32'(out_valid), 1);
        flush = 1; in_ir = 32'h0020_81B3;
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        step();
        flush = 0; in_valid = 0;
        chk("fl_dropped", 32'(out_valid), 0);
        chk("fl_cnt", 32'(decoded_cnt), 5);
        step();
        chk("fl_no_accept", 32'(out_valid), 0);

        // Stream 16 legal instructions to wrap the 4-bit counter
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            in_ir = legal[i % 8]; in_pc = 32'h400 + 32'(4 * i);
            step();
            if (i == 1) chk("lw_imm", out_imm, 32'hFFFF_FFFC);
            if (i == 11) chk("wrap_zero", 32'(decoded_cnt), 0);
        end
        in_valid = 0;
        step();
        chk("wrap_full", 32'(decoded_cnt), 5);

        // Reset mid-stream
        in_valid = 1; in_ir = legal[5];
        step();
        step();
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 0;
        step();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_cnt", 32'(decoded_cnt), 0);
        rst_n = 1; in_valid = 0;
        step();
        chk("post_rst_cnt", 32'(decoded_cnt), 0);
        step();
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
